delay_scan_controller: RTL

//  Automates TDC delay sweeps. Steps the chip-B delay code from d_start to d_stop, holding chip A at d_ref.
//  At each point it programs the delay block, waits for settling, then fires the TDC sequencer `repeats` times.

---
 rtl/delay_scan_controller.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/delay_scan_controller.sv
// rtl/delay_scan_controller.sv - Automated chip-B delay sweep with settle, repeat and timeout control
module delay_scan_controller #(
  parameter int DW    = 10,
  parameter int GAP   = 4,
  parameter int TMO_W = 16
) (
  input  logic          clk,
  input  logic          res_n,
  input  logic          start,
  input  logic          abort,
  input  logic [DW-1:0] d_ref,
  input  logic [DW-1:0] d_start,
  input  logic [DW-1:0] d_stop,
  input  logic [DW-1:0] d_step,
  input  logic [7:0]    repeats,
  input  logic [7:0]    settle,
  output logic          del_set,
  output logic          del_sel,
  output logic [DW-1:0] del_d,
  output logic          seq_run,
  input  logic          seq_ready,
  output logic          pt_strobe,
  output logic [DW-1:0] cur_d,
  output logic [7:0]    rep_cnt,
  output logic          busy,
  output logic          done,
  output logic          err_cfg,
  output logic          err_tmo
);

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_SETA, S_GAPW, S_SETB, S_SETL,
    S_RUN, S_HOLD, S_WAIT, S_NEXT, S_FIN
  } state_t;

  // Last count value of the fixed A-to-B gap and of the WAIT timeout window
  localparam logic [7:0]       GAP_LAST = 8'(GAP - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  state_t           state, next;
  logic [DW-1:0]    cfg_ref, cfg_start, cfg_stop, cfg_step;
  logic [7:0]       cfg_reps, cfg_settle;
  logic [7:0]       wcnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic [DW:0]      sum;
  logic             cfg_bad;
  logic             accept, chk_fail, chk_ok, run_ok, tmo_hit, adv_pt;

  // One extra bit so a step past the top code is seen as carry instead of wrapping
  assign sum     = {1'b0, cur_d} + {1'b0, cfg_step};
  assign cfg_bad = (cfg_step == '0) || (cfg_start > cfg_stop);

  // State register
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) state <= S_IDLE;
    else        state <= next;
  end

  // Next-state decode and pulse outputs; abort overrides every transition and pulse
  always_comb begin
    next      = state;
    del_set   = 1'b0;
    del_sel   = 1'b0;
    del_d     = '0;
    seq_run   = 1'b0;
    pt_strobe = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    chk_fail  = 1'b0;
    chk_ok    = 1'b0;
    run_ok    = 1'b0;
    tmo_hit   = 1'b0;
    adv_pt    = 1'b0;
    busy      = (state != S_IDLE);
    if (busy && abort) begin
      next = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && seq_ready) begin
            accept = 1'b1;
            next   = S_CHECK;
          end
        end
        S_CHECK: begin
          if (cfg_bad) begin
            chk_fail = 1'b1;
            next     = S_FIN;
          end else begin
            chk_ok = 1'b1;
            next   = S_SETA;
          end
        end
        S_SETA: begin
          del_set = 1'b1;
          del_d   = cfg_ref;
          next    = S_GAPW;
        end
        S_GAPW: begin
          if (wcnt == GAP_LAST) next = S_SETB;
        end
        S_SETB: begin
          del_set = 1'b1;
          del_sel = 1'b1;
          del_d   = cur_d;
          next    = (cfg_settle == 8'd0) ? S_RUN : S_SETL;
        end
        S_SETL: begin
          if (wcnt == cfg_settle - 8'd1) next = S_RUN;
        end
        S_RUN: begin
          seq_run = 1'b1;
          next    = S_HOLD;
        end
        S_HOLD: begin
          if (wcnt == 8'd1) next = S_WAIT;
        end
        S_WAIT: begin
          if (seq_ready) begin
            pt_strobe = 1'b1;
            run_ok    = 1'b1;
            next      = S_NEXT;
          end else if (tmo_cnt == TMO_LAST) begin
            tmo_hit = 1'b1;
            next    = S_FIN;
          end
        end
        S_NEXT: begin
          if (rep_cnt < cfg_reps) begin
            next = S_RUN;
          end else if (sum[DW] || (sum[DW-1:0] > cfg_stop)) begin
            next = S_FIN;
          end else begin
            adv_pt = 1'b1;
            next   = S_SETB;
          end
        end
        S_FIN: begin
          done = 1'b1;
          next = S_IDLE;
        end
        default: next = S_IDLE;
      endcase
    end
  end

  // Capture the scan configuration on an accepted start; later input changes are ignored
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      cfg_ref    <= '0;
      cfg_start  <= '0;
      cfg_stop   <= '0;
      cfg_step   <= '0;
      cfg_reps   <= '0;
      cfg_settle <= '0;
    end else if (accept) begin
      cfg_ref    <= d_ref;
      cfg_start  <= d_start;
      cfg_stop   <= d_stop;
      cfg_step   <= d_step;
      cfg_reps   <= (repeats == 8'd0) ? 8'd1 : repeats;
      cfg_settle <= settle;
    end
  end

  // Dwell counter for GAPW, SETL and HOLD; restarts on every state change
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n)              wcnt <= '0;
    else if (next != state)  wcnt <= '0;
    else                     wcnt <= wcnt + 8'd1;
  end

  // Ready timeout counter: cleared entering HOLD, advances once per WAIT cycle
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n)                                tmo_cnt <= '0;
    else if (next == S_HOLD && state != S_HOLD) tmo_cnt <= '0;
    else if (state == S_WAIT)                  tmo_cnt <= tmo_cnt + TMO_W'(1);
  end

  // Scan position, per-point run count and sticky error flags
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      cur_d   <= '0;
      rep_cnt <= '0;
      err_cfg <= 1'b0;
      err_tmo <= 1'b0;
    end else begin
      if (accept) begin
        err_cfg <= 1'b0;
        err_tmo <= 1'b0;
      end
      if (chk_fail) err_cfg <= 1'b1;
      if (tmo_hit)  err_tmo <= 1'b1;
      if (chk_ok) begin
        cur_d   <= cfg_start;
        rep_cnt <= '0;
      end
      if (run_ok) rep_cnt <= rep_cnt + 8'd1;
      if (adv_pt) begin
        cur_d   <= sum[DW-1:0];
        rep_cnt <= '0;
      end
    end
  end

endmodule
